// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812/SK6812 frame sequencer.
// Latency: not applicable (types, constants and a pure function).
// Backpressure: not applicable.
package ws2812_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_CAP   = 3'd2,
        S_SEND_BIT = 3'd3,
        S_SEND_RST = 3'd4
    } state_e;

    // 50 us line-reset gap at 200 MHz
    localparam int RST_CYCLES_DEFAULT = 10000;

    // Brightness scale of one 8-bit channel: (c * (bright + 1)) >> 8, truncated.
    // bright = 255 multiplies by 256, which makes the scale an exact identity.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_frame_ctl_pixel_scale.sv
// Applies global brightness to every 8-bit channel of one pixel word.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
module pixel_scale
    import ws2812_pkg::*;
#(
    parameter int PIXEL_BITS = 24
) (
    input  logic [PIXEL_BITS-1:0] pixel_i,
    input  logic [7:0]            bright_i,
    output logic [PIXEL_BITS-1:0] pixel_o
);

    localparam int NUM_CH = PIXEL_BITS / 8;

    // One independent scaler per channel; channel order is preserved as stored
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pixel_o[g*8 +: 8] = scale8(pixel_i[g*8 +: 8], bright_i);
    end

endmodule

// File: rtl/ws2812_frame_ctl.sv
// Frame sequencer: reads pixels from frame RAM, scales them and feeds the bit encoder MSB-first.
// Latency: frame start sampled at edge N -> RAM read in cycle N+1 -> first bit_rdy_out in cycle N+3.
// Backpressure: one bit outstanding; the next bit waits for the encoder's bit_done_in pulse.
module ws2812_frame_ctl
    import ws2812_pkg::*;
#(
    parameter int PIXEL_BITS = 24,
    parameter int ADDR_BITS  = 6,
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  frame_rdy_in,
    input  logic [ADDR_BITS:0]    pixel_cnt_in,
    input  logic [7:0]            bright_in,
    output logic                  ram_rd_en_out,
    output logic [ADDR_BITS-1:0]  ram_rd_addr_out,
    input  logic [PIXEL_BITS-1:0] ram_rd_data_in,
    input  logic                  bit_done_in,
    output logic                  bit_rdy_out,
    output logic                  bit_data_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int CW = ADDR_BITS + 1;
    localparam int BW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e                 state_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [CW-1:0]          cnt_q;
    logic [7:0]             bright_q;
    logic [BW-1:0]          bit_idx_q;
    logic [RW-1:0]          rst_cnt_q;
    logic [PIXEL_BITS-1:0]  shift_q;
    logic                   pending_q;
    logic                   rd_en_q;
    logic                   bit_rdy_q;
    logic                   bit_data_q;
    logic                   frame_done_q;

    logic [PIXEL_BITS-1:0]  scaled_d;
    logic                   bit_take_d;
    logic                   last_bit_d;
    logic                   last_pix_d;
    logic                   rst_end_d;

    pixel_scale #(
        .PIXEL_BITS (PIXEL_BITS)
    ) u_scale (
        .pixel_i  (ram_rd_data_in),
        .bright_i (bright_q),
        .pixel_o  (scaled_d)
    );

    // A done pulse only counts for a bit that is outstanding and not in its own rdy cycle
    assign bit_take_d = bit_done_in && pending_q && !bit_rdy_q;
    assign last_bit_d = (bit_idx_q == BW'(PIXEL_BITS - 1));
    // cnt is one bit wider than addr so a full-depth frame ends at DEPTH-1 without wrapping
    assign last_pix_d = ({1'b0, addr_q} == (cnt_q - CW'(1)));
    assign rst_end_d  = (rst_cnt_q == RW'(RST_CYCLES - 1));

    assign ram_rd_en_out   = rd_en_q;
    assign ram_rd_addr_out = addr_q;
    assign bit_rdy_out     = bit_rdy_q;
    assign bit_data_out    = bit_data_q;
    assign busy_out        = (state_q != S_IDLE);
    assign frame_done_out  = frame_done_q;

    // Frame FSM with address, bit and gap counters, shift register and pending flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            bright_q     <= '0;
            bit_idx_q    <= '0;
            rst_cnt_q    <= '0;
            shift_q      <= '0;
            pending_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            bit_rdy_q    <= 1'b0;
            bit_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            bit_rdy_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_rdy_in) begin
                        cnt_q     <= pixel_cnt_in;
                        bright_q  <= bright_in;
                        addr_q    <= '0;
                        rst_cnt_q <= '0;
                        if (pixel_cnt_in == '0) begin
                            state_q <= S_SEND_RST;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    state_q <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    shift_q    <= scaled_d;
                    bit_idx_q  <= '0;
                    bit_data_q <= scaled_d[PIXEL_BITS-1];
                    bit_rdy_q  <= 1'b1;
                    pending_q  <= 1'b1;
                    state_q    <= S_SEND_BIT;
                end
                S_SEND_BIT: begin
                    if (bit_take_d) begin
                        pending_q <= 1'b0;
                        if (!last_bit_d) begin
                            bit_idx_q  <= bit_idx_q + 1'b1;
                            shift_q    <= shift_q << 1;
                            bit_data_q <= shift_q[PIXEL_BITS-2];
                            bit_rdy_q  <= 1'b1;
                            pending_q  <= 1'b1;
                        end else if (last_pix_d) begin
                            rst_cnt_q <= '0;
                            state_q   <= S_SEND_RST;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            rd_en_q <= 1'b1;
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_SEND_RST: begin
                    if (rst_end_d) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
